// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator unit: opcode encodings, FSM states, default width.
package acc_pkg;

    localparam int unsigned WIDTH = 8;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

endpackage

// File: rtl/acc_alu.sv
// Combinational single-cycle result and carry for NOP/LOAD/ADD/SUB/AND/OR.
module acc_alu #(
    parameter int unsigned WIDTH = acc_pkg::WIDTH
) (
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] operand,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    import acc_pkg::*;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum = {1'b0, a} + {1'b0, operand};
        // Bit WIDTH of the extended difference is the borrow (operand > a).
        diff = {1'b0, a} - {1'b0, operand};
        result = a;
        carry_out = carry_in;
        case (op_code)
            OP_NOP: begin
                result = a;
                carry_out = carry_in;
            end
            OP_LOAD: begin
                result = operand;
                carry_out = 1'b0;
            end
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry_out = diff[WIDTH];
            end
            OP_AND: begin
                result = a & operand;
                carry_out = 1'b0;
            end
            OP_OR: begin
                result = a | operand;
                carry_out = 1'b0;
            end
            default: begin
                result = a;
                carry_out = carry_in;
            end
        endcase
    end

endmodule

// File: rtl/acc_unit.sv
// Accumulator with valid/ready op interface; shifts run one bit per clock under a small FSM.
module acc_unit #(
    parameter int unsigned WIDTH = acc_pkg::WIDTH,
    parameter int unsigned SH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] A_out,
    output logic             carry,
    output logic             zero,
    output logic             done
);
    import acc_pkg::*;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic               carry_q;
    logic               zero_q;
    logic               done_q;
    logic [SH_BITS-1:0] cnt_q;
    logic               left_q;

    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic [WIDTH-1:0]   shifted;
    logic               shift_out;
    logic [SH_BITS-1:0] sh_amt;
    logic               is_shift;

    acc_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op_code  (op_code),
        .a        (a_q),
        .operand  (operand),
        .carry_in (carry_q),
        .result   (alu_result),
        .carry_out(alu_carry)
    );

    always_comb begin
        sh_amt = operand[SH_BITS-1:0];
        is_shift = (op_code == OP_SHL) || (op_code == OP_SHR);
        if (left_q) begin
            shifted = {a_q[WIDTH-2:0], 1'b0};
            shift_out = a_q[WIDTH-1];
        end else begin
            shifted = {1'b0, a_q[WIDTH-1:1]};
            shift_out = a_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            carry_q <= 1'b0;
            zero_q <= 1'b1;
            done_q <= 1'b0;
            cnt_q <= '0;
            left_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        if (is_shift && (sh_amt != '0)) begin
                            // A is left untouched on the accept edge; shifting starts next edge.
                            left_q <= (op_code == OP_SHL);
                            cnt_q <= sh_amt;
                            state_q <= SHIFT;
                        end else if (is_shift) begin
                            carry_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            a_q <= alu_result;
                            carry_q <= alu_carry;
                            zero_q <= (alu_result == '0);
                            done_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    a_q <= shifted;
                    carry_q <= shift_out;
                    zero_q <= (shifted == '0);
                    cnt_q <= cnt_q - SH_BITS'(1);
                    if (cnt_q == SH_BITS'(1)) begin
                        state_q <= IDLE;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign op_ready = (state_q == IDLE);
    assign A_out = a_q;
    assign carry = carry_q;
    assign zero = zero_q;
    assign done = done_q;

endmodule

// File: doc/acc_unit.md
Name: acc_unit

Overview:
- 8-bit accumulator datapath that produces the `A_out` bus and a registered zero flag.
- It is the producing end of the accumulator interface whose consumers are the zero-detect logic and the control unit.
- Accepts one operation per valid/ready handshake. Shifts are multi-cycle, one bit per clock, under a small FSM.
- Sits between the instruction/control unit (op source) and the flag/branch logic (`A_out` consumer).

Parameters:
- WIDTH, 8, accumulator and operand width in bits.
- SH_BITS, 3, width of shift-amount field taken from operand[SH_BITS-1:0]. Maximum shift is 2^SH_BITS-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  requester has an operation on op_code/operand.
- op_ready  output  1  unit can accept an operation this cycle.
- op_code  input  3  operation select; encodings below.
- operand  input  WIDTH  data operand, or shift amount in its low SH_BITS bits.
- A_out  output  WIDTH  accumulator register value.
- carry  output  1  carry/borrow/shifted-out bit, registered.
- zero  output  1  registered; 1 iff A_out == 0.
- done  output  1  one-cycle pulse when an accepted operation completes.

Behaviour:
- Reset (rst_n low, async):
  - A_out=0, carry=0, zero=1, done=0.
  - FSM=IDLE, shift counter=0, so op_ready=1 once reset deasserts.
  - Reset mid-shift aborts the operation; no done pulse.
- Handshake:
  - Transfer occurs on a rising edge where op_valid && op_ready.
  - op_ready = (state==IDLE), combinational from state only, never from op_valid.
  - op_valid while op_ready=0 is ignored, with no queuing. The requester holds its request.
- Op encodings:
  - 000 NOP: A and carry unchanged.
  - 001 LOAD: A=operand, carry=0.
  - 010 ADD: {carry,A}=A+operand, computed at WIDTH+1 bits.
  - 011 SUB: A=A-operand mod 2^WIDTH; carry=1 iff operand>A (borrow).
  - 100 AND: A=A&operand, carry=0.
  - 101 OR: A=A|operand, carry=0.
  - 110 SHL by n=operand[SH_BITS-1:0], zero fill.
  - 111 SHR logical by n, zero fill.
- Single-cycle ops (000-101, and shifts with n=0):
  - Result is registered on the accept edge.
  - done=1 for the following cycle.
  - FSM stays IDLE, so back-to-back accepts are possible every cycle.
  - Shift with n=0: A unchanged, carry=0.
- Shift with n>0:
  - Accept edge: latch direction, count=n, state goes to SHIFT. A is not changed on this edge.
  - Each SHIFT cycle shifts A by 1. carry takes the bit shifted out (A[WIDTH-1] for SHL, A[0] for SHR). count decrements.
  - On the edge where count goes 1->0: state goes to IDLE and done pulses the next cycle.
  - Total latency is n+1 edges from accept to IDLE. op_ready returns high in the cycle done is high.
- zero: registered in the same edge as every A update, from the next-A value. It is never combinational from A_out.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow wraps silently; only carry reports it.

Decomposition:
- Shared package acc_pkg holds:
  - localparams OP_NOP..OP_SHR (3-bit);
  - state enum IDLE/SHIFT;
  - WIDTH default.
- One natural sub-module: acc_alu, the combinational single-cycle result plus carry for ops 000-101.
- FSM, shifter and registers stay in acc_unit.

Test Plan:
- Reset, then LOAD 0x00 -> A_out=0x00, zero=1, carry=0, done pulses 1 cycle after accept.
- LOAD 0xF0, then ADD 0x20 back-to-back -> A_out=0x10, carry=1, zero=0. op_ready stays 1 throughout.
- LOAD 0x05, SUB 0x05 -> A_out=0x00, zero=1, carry=0. Then SUB 0x01 -> A_out=0xFF, carry=1, zero=0.
- LOAD 0x81, SHL n=3:
  - op_ready low for exactly 3 cycles;
  - intermediate A values 0x02, 0x04, 0x08;
  - final carry=0 (bit out on last step was 0; check carry=1 after the first step);
  - done pulses once.
- During the SHR n=7 of 0x80, hold op_valid with LOAD 0x55 -> the LOAD is not taken until op_ready=1. Final A=0x01 then 0x55.
- Assert rst_n low on the 2nd cycle of an SHL n=5 -> all outputs return to reset values immediately. No done. op_ready=1 after release.
